// File: rtl/pwm_peripheral_if.sv
// Configuration/status bundle between the SPI register file and the PWM
// output stage. The master side owns the five configuration registers and
// the peripheral (slave) side owns the user outputs and the period marker.
interface pwm_peripheral_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  modport master (
    output en_reg_out_7_0,
    output en_reg_out_15_8,
    output en_reg_pwm_7_0,
    output en_reg_pwm_15_8,
    output pwm_duty_cycle,
    input  out,
    input  period_start
  );

  modport slave (
    input  en_reg_out_7_0,
    input  en_reg_out_15_8,
    input  en_reg_pwm_7_0,
    input  en_reg_pwm_15_8,
    input  pwm_duty_cycle,
    output out,
    output period_start
  );
endinterface

// File: rtl/pwm_peripheral.sv
// PWM output stage: 16 user outputs, each forced low, held high or driven by
// one shared 8-bit PWM waveform. A prescaler slows the PWM counter, the
// counter runs 0..254 (255 ticks per period) and the duty cycle is
// double-buffered so a new value only takes effect at a period boundary.
module pwm_peripheral #(
  parameter  int CLK_DIV = 13,
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  pwm_peripheral_if.slave  bus
);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [7:0]       CNT_LAST  = 8'd254;
  localparam logic [7:0]       DUTY_FULL = 8'hFF;

  logic [DIV_W-1:0] prescaler_r;
  logic [7:0]       pwm_cnt_r;
  logic [7:0]       duty_shadow_r;
  logic [15:0]      out_r;
  logic             period_start_r;

  logic             tick_s;
  logic             wrap_s;
  logic             pwm_level_s;
  logic [15:0]      en_out_s;
  logic [15:0]      en_pwm_s;
  logic [15:0]      out_next_s;

  // Counter strobes: one tick per CLK_DIV clocks, wrap on the last tick of a period
  always_comb begin
    tick_s = 1'b0;
    wrap_s = 1'b0;
    if (prescaler_r == DIV_LAST) begin
      tick_s = 1'b1;
      if (pwm_cnt_r == CNT_LAST) begin
        wrap_s = 1'b1;
      end else begin
        wrap_s = 1'b0;
      end
    end else begin
      tick_s = 1'b0;
      wrap_s = 1'b0;
    end
  end

  // Shared PWM level; full-scale duty is forced high so the wrap cycle cannot glitch low
  always_comb begin
    pwm_level_s = 1'b0;
    if (duty_shadow_r == DUTY_FULL) begin
      pwm_level_s = 1'b1;
    end else begin
      pwm_level_s = (pwm_cnt_r < duty_shadow_r);
    end
  end

  // Per-bit output select: disabled -> 0, enabled static -> 1, enabled PWM -> level
  always_comb begin
    en_out_s   = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    en_pwm_s   = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
    out_next_s = en_out_s & (~en_pwm_s | {16{pwm_level_s}});
  end

  // Prescaler: counts 0..CLK_DIV-1 and wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_r <= '0;
    end else if (tick_s) begin
      prescaler_r <= '0;
    end else begin
      prescaler_r <= prescaler_r + DIV_ONE;
    end
  end

  // PWM counter: advances on each tick, 254 wraps to 0 so 255 is never reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_r <= 8'd0;
    end else if (wrap_s) begin
      pwm_cnt_r <= 8'd0;
    end else if (tick_s) begin
      pwm_cnt_r <= pwm_cnt_r + 8'd1;
    end else begin
      pwm_cnt_r <= pwm_cnt_r;
    end
  end

  // Duty shadow: captures the requested duty only on the wrap edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow_r <= 8'h00;
    end else if (wrap_s) begin
      duty_shadow_r <= bus.pwm_duty_cycle;
    end else begin
      duty_shadow_r <= duty_shadow_r;
    end
  end

  // Period marker: one-clock pulse in the first cycle with pwm_cnt==0 after a wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_start_r <= 1'b0;
    end else begin
      period_start_r <= wrap_s;
    end
  end

  // Output register: enables act immediately, one clock after they change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r <= 16'h0000;
    end else begin
      out_r <= out_next_s;
    end
  end

  assign bus.out          = out_r;
  assign bus.period_start = period_start_r;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral. Two instances (CLK_DIV=4 and
// CLK_DIV=1) share clock, reset and configuration. A reference model derives
// the expected outputs from elapsed clocks since reset with plain arithmetic;
// directed period measurements cover the high-time and boundary cases.
module tb_pwm_peripheral;

  localparam int unsigned P4 = 255 * 4;
  localparam int unsigned P1 = 255;

  logic clk;
  logic rst_n;

  logic [15:0] cfg_en_out;
  logic [15:0] cfg_en_pwm;
  logic [7:0]  cfg_duty;

  int n_pass;
  int n_total;

  pwm_peripheral_if bus4 ();
  pwm_peripheral_if bus1 ();

  pwm_peripheral #(.CLK_DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  pwm_peripheral #(.CLK_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  assign bus4.en_reg_out_7_0  = cfg_en_out[7:0];
  assign bus4.en_reg_out_15_8 = cfg_en_out[15:8];
  assign bus4.en_reg_pwm_7_0  = cfg_en_pwm[7:0];
  assign bus4.en_reg_pwm_15_8 = cfg_en_pwm[15:8];
  assign bus4.pwm_duty_cycle  = cfg_duty;
  assign bus1.en_reg_out_7_0  = cfg_en_out[7:0];
  assign bus1.en_reg_out_15_8 = cfg_en_out[15:8];
  assign bus1.en_reg_pwm_7_0  = cfg_en_pwm[7:0];
  assign bus1.en_reg_pwm_15_8 = cfg_en_pwm[15:8];
  assign bus1.pwm_duty_cycle  = cfg_duty;

  // Clock: 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected output from enables, counter phase and the duty in force
  function automatic logic [15:0] exp_out(input logic [15:0] eo, input logic [15:0] ep,
                                          input int unsigned cnt, input logic [7:0] sh);
    logic lvl;
    lvl = (sh == 8'hFF) || (cnt < int'(sh));
    return eo & (~ep | {16{lvl}});
  endfunction

  // Reference model: t = clocks since reset release; counter phase = (t/div) mod 255;
  // the duty is sampled every 255*div clocks; out lags the level by one clock.
  int unsigned t4, t1;
  logic [7:0]  sh4, sh1;
  logic [15:0] mo4, mo1;
  logic        mp4, mp1;

  // Model state update at each clock, cleared by reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t4 <= 0; sh4 <= 8'h00; mo4 <= 16'h0000; mp4 <= 1'b0;
      t1 <= 0; sh1 <= 8'h00; mo1 <= 16'h0000; mp1 <= 1'b0;
    end else begin
      mo4 <= exp_out(cfg_en_out, cfg_en_pwm, (t4 / 4) % 255, sh4);
      t4  <= t4 + 1;
      mp4 <= ((t4 + 1) % P4 == 0);
      if ((t4 + 1) % P4 == 0) sh4 <= cfg_duty;
      mo1 <= exp_out(cfg_en_out, cfg_en_pwm, t1 % 255, sh1);
      t1  <= t1 + 1;
      mp1 <= ((t1 + 1) % P1 == 0);
      if ((t1 + 1) % P1 == 0) sh1 <= cfg_duty;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check_eq("out_div4", {16'h0000, bus4.out}, {16'h0000, mo4});
    check_eq("ps_div4", {31'd0, bus4.period_start}, {31'd0, mp4});
    check_eq("out_div1", {16'h0000, bus1.out}, {16'h0000, mo1});
    check_eq("ps_div1", {31'd0, bus1.period_start}, {31'd0, mp1});
  end

  function automatic logic [15:0] out_of(input int which);
    return (which == 1) ? bus1.out : bus4.out;
  endfunction

  function automatic logic ps_of(input int which);
    return (which == 1) ? bus1.period_start : bus4.period_start;
  endfunction

  task automatic wait_ps(input int which);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (ps_of(which)) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_eq("wait_ps_timeout", 32'd0, 32'd1);
  endtask

  // Counts clocks and out[0]-high clocks up to and including the next period_start
  task automatic measure(input int which, input int change_at, input logic [7:0] new_duty,
                         output int hi, output int len, output logic [15:0] upper);
    logic [15:0] o;
    hi = 0;
    len = 0;
    upper = 16'h0000;
    do begin
      @(negedge clk);
      len++;
      o = out_of(which);
      if (o[0]) hi++;
      upper = upper | (o & 16'hFFFE);
      if (len == change_at) cfg_duty = new_duty;
    end while (!ps_of(which) && len < 3000);
  endtask

  int          hi, len;
  logic [15:0] upper;
  logic [7:0]  rd;

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    cfg_en_out = 16'h0000;
    cfg_en_pwm = 16'h0000;
    cfg_duty = 8'h00;

    // 1: reset holds outputs low whatever the inputs do
    repeat (2) @(negedge clk);
    cfg_en_out = 16'hFFFF;
    cfg_en_pwm = 16'h5A5A;
    cfg_duty = 8'($urandom_range(0, 255));
    repeat (3) @(negedge clk);
    check_eq("rst_out4", {16'h0000, bus4.out}, 32'h0);
    check_eq("rst_ps4", {31'd0, bus4.period_start}, 32'h0);
    check_eq("rst_out1", {16'h0000, bus1.out}, 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    measure(0, 0, 8'h00, hi, len, upper);
    check_eq("first_ps_delay", 32'(len), 32'd1021);
    measure(0, 0, 8'h00, hi, len, upper);
    check_eq("ps_interval", 32'(len), 32'd1020);

    // 2: enables take effect one clock after they change
    @(negedge clk);
    cfg_en_out = 16'hFFFF; cfg_en_pwm = 16'h0000;
    @(negedge clk);
    check_eq("en_static", {16'h0000, bus4.out}, 32'h0000FFFF);
    cfg_en_out = 16'h00F0;
    @(negedge clk);
    check_eq("en_partial", {16'h0000, bus4.out}, 32'h000000F0);
    cfg_en_out = 16'h0000; cfg_en_pwm = 16'hFFFF;
    @(negedge clk);
    check_eq("en_off_pwm", {16'h0000, bus4.out}, 32'h00000000);

    // 3: 50 %, 0 % and 100 % duty
    cfg_en_out = 16'hFFFF; cfg_en_pwm = 16'hFFFF; cfg_duty = 8'h80;
    wait_ps(0);
    measure(0, 0, 8'h00, hi, len, upper);
    check_eq("d80_hi", 32'(hi), 32'd512);
    check_eq("d80_len", 32'(len), 32'd1020);
    cfg_duty = 8'h00;
    measure(0, 0, 8'h00, hi, len, upper);
    check_eq("d80_held", 32'(hi), 32'd512);
    measure(0, 0, 8'h00, hi, len, upper);
    check_eq("d00_hi", 32'(hi), 32'd0);
    cfg_duty = 8'hFF;
    measure(0, 0, 8'h00, hi, len, upper);
    check_eq("d00_held", 32'(hi), 32'd0);
    for (int p = 0; p < 3; p++) begin
      measure(0, 0, 8'h00, hi, len, upper);
      check_eq("dFF_hi", 32'(hi), 32'd1020);
    end

    // 4: mid-period duty change lands on the next period only
    cfg_duty = 8'h40;
    measure(0, 0, 8'h00, hi, len, upper);
    check_eq("dFF_before_40", 32'(hi), 32'd1020);
    measure(0, 300, 8'hC0, hi, len, upper);
    check_eq("d40_kept", 32'(hi), 32'd256);
    measure(0, 0, 8'h00, hi, len, upper);
    check_eq("dC0_hi", 32'(hi), 32'd768);

    // 5: minimum duty with CLK_DIV=1, only bit 0 enabled
    cfg_en_out = 16'h0001; cfg_en_pwm = 16'h0001; cfg_duty = 8'h01;
    wait_ps(1);
    measure(1, 0, 8'h00, hi, len, upper);
    check_eq("d01_hi", 32'(hi), 32'd1);
    check_eq("d01_len", 32'(len), 32'd255);
    check_eq("d01_upper", {16'h0000, upper}, 32'h0);

    // Random phase: random enables/duty every few clocks, checked by the model
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        cfg_en_out = 16'($urandom);
        cfg_en_pwm = 16'($urandom);
        cfg_duty = 8'($urandom);
      end
    end
    cfg_en_out = 16'hFFFF; cfg_en_pwm = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      rd = 8'($urandom);
      cfg_duty = rd;
      wait_ps(0);
      measure(0, 0, 8'h00, hi, len, upper);
      check_eq("rand_duty_hi", 32'(hi), (rd == 8'hFF) ? 32'd1020 : 32'(rd) * 32'd4);
    end

    // 6: short reset mid-period discards the period and the shadow duty
    cfg_duty = 8'h80;
    wait_ps(0);
    measure(0, 0, 8'h00, hi, len, upper);
    check_eq("pre_rst_hi", 32'(hi), 32'd512);
    repeat (300) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check_eq("async_out4", {16'h0000, bus4.out}, 32'h0);
    check_eq("async_ps4", {31'd0, bus4.period_start}, 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    measure(0, 0, 8'h00, hi, len, upper);
    check_eq("post_rst_len", 32'(len), 32'd1021);
    check_eq("post_rst_hi", 32'(hi), 32'd0);
    measure(0, 0, 8'h00, hi, len, upper);
    check_eq("resume_hi", 32'(hi), 32'd512);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
